// File: rtl/mips_cache_writebuffer_coalesce_if.sv
// Bundles the cache write port, Avalon-MM write master, forwarding probe and occupancy status
// of the posted-write buffer.
// Modports: slave = the write buffer itself, master = its environment (cache and Avalon slave).
interface mips_cache_writebuffer_coalesce_if #(
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH);

  // cache write port
  logic             in_valid;
  logic [31:0]      in_addr;
  logic [31:0]      in_data;
  logic [3:0]       in_byteenable;
  logic             in_ready;
  // Avalon-MM write master
  logic [31:0]      avm_address;
  logic             avm_write;
  logic [31:0]      avm_writedata;
  logic [3:0]       avm_byteenable;
  logic             avm_waitrequest;
  // read-forwarding probe
  logic [31:0]      lookup_addr;
  logic             lookup_hit;
  logic [31:0]      lookup_data;
  logic [3:0]       lookup_byteenable;
  // occupancy
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;

  modport slave (
    input  in_valid, in_addr, in_data, in_byteenable,
    output in_ready,
    output avm_address, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest,
    input  lookup_addr,
    output lookup_hit, lookup_data, lookup_byteenable,
    output count, full, empty
  );

  modport master (
    output in_valid, in_addr, in_data, in_byteenable,
    input  in_ready,
    input  avm_address, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest,
    output lookup_addr,
    input  lookup_hit, lookup_data, lookup_byteenable,
    input  count, full, empty
  );
endinterface

// File: rtl/mips_cache_writebuffer_coalesce.sv
// Posted-write FIFO between data cache and Avalon-MM master, with read forwarding.
// Latency: write accepted at edge N drives avm_write in cycle N+1; lookup sees it from N+1.
// Backpressure: in_ready drops when full (unless merging); head held stable under avm_waitrequest.
//
// Ports: clk, rst_n (synchronous, active low), bus (slave modport of
//   mips_cache_writebuffer_coalesce_if: cache write port, Avalon write master,
//   combinational lookup probe, count/full/empty).
// Optional feature macro: WB_COALESCE_EN -- merge same-word writes into a non-head entry.
module mips_cache_writebuffer_coalesce #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic                            clk,
  input logic                            rst_n,
  mips_cache_writebuffer_coalesce_if.slave bus
);

  localparam int CNT_W = PTR_W + 1;

  // entry storage; valid bits and pointers are reset, payload is not
  logic [DEPTH-1:0] vld_q;
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             full_q;
  logic             empty_q;

  logic [29:0]      in_word;
  logic             merge_hit;
  logic             accept;
  logic             has_lanes;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_nxt;

  assign in_word   = bus.in_addr[31:2];
  assign has_lanes = |bus.in_byteenable;

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] merge_idx;
  logic             do_merge;

  // The head may already be on the bus, so it is excluded from merging.
  // At most one non-head entry can hold a given word, so any match is the match.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (PTR_W'(i) != head_q) && (addr_q[i] == in_word)) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(i);
      end
    end
  end

  assign do_merge = accept && has_lanes && merge_hit;
`else
  assign merge_hit = 1'b0;
`endif

  // No full-bypass: a pop in the same cycle does not free a slot for the write.
  assign bus.in_ready = !full_q || merge_hit;
  assign accept       = bus.in_valid && bus.in_ready;
  // An all-lanes-off write is acknowledged and dropped.
  assign push         = accept && has_lanes && !merge_hit;
  assign pop          = !empty_q && !bus.avm_waitrequest;
  assign count_nxt    = count_q + CNT_W'(push) - CNT_W'(pop);

  // control state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      // push and pop never target the same slot: tail==head only when empty (no pop)
      // or full (no push)
      if (push) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  // payload
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_word;
      data_q[tail_q] <= bus.in_data;
      be_q[tail_q]   <= bus.in_byteenable;
    end
`ifdef WB_COALESCE_EN
    if (do_merge) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.in_byteenable[l]) begin
          data_q[merge_idx][8*l +: 8] <= bus.in_data[8*l +: 8];
        end
      end
      be_q[merge_idx] <= be_q[merge_idx] | bus.in_byteenable;
    end
`endif
  end

  // head drives the bus straight from registers; zeros when nothing is pending
  assign bus.avm_write      = !empty_q;
  assign bus.avm_address    = empty_q ? 32'h0 : {addr_q[head_q], 2'b00};
  assign bus.avm_writedata  = empty_q ? 32'h0 : data_q[head_q];
  assign bus.avm_byteenable = empty_q ? 4'h0  : be_q[head_q];

  assign bus.count = count_q;
  assign bus.full  = full_q;
  assign bus.empty = empty_q;

  // Forwarding: walk entries oldest to youngest so younger lanes overwrite older ones.
  // Valid entries are contiguous from the head, so wrap-around indexing gives age order.
  logic [PTR_W-1:0] lk_idx;
  logic [31:0]      lk_data;
  logic [3:0]       lk_be;

  always_comb begin
    lk_idx  = '0;
    lk_data = 32'h0;
    lk_be   = 4'h0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = head_q + PTR_W'(k);
      if (vld_q[lk_idx] && (addr_q[lk_idx] == bus.lookup_addr[31:2])) begin
        for (int l = 0; l < 4; l++) begin
          if (be_q[lk_idx][l]) begin
            lk_data[8*l +: 8] = data_q[lk_idx][8*l +: 8];
            lk_be[l]          = 1'b1;
          end
        end
      end
    end
  end

  assign bus.lookup_data       = lk_data;
  assign bus.lookup_byteenable = lk_be;
  assign bus.lookup_hit        = |lk_be;

  // byte offsets are ignored on word-granular paths
  logic unused_ok;
  assign unused_ok = ^{bus.in_addr[1:0], bus.lookup_addr[1:0]};

endmodule

// File: tb/tb_mips_cache_writebuffer_coalesce.sv
module tb_mips_cache_writebuffer_coalesce;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_cache_writebuffer_coalesce_if #(.DEPTH(DEPTH)) wb ();

  mips_cache_writebuffer_coalesce #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wb)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // reference model: queue of pending words, oldest at index 0
  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // index of a non-head pending entry for this word, or -1
  function automatic int find_merge(input logic [29:0] w);
`ifdef WB_COALESCE_EN
    for (int j = 1; j < q.size(); j++) if (q[j].a == w) return j;
`endif
    return -1;
  endfunction

  task automatic model_check();
    logic [3:0]  eb;
    logic [31:0] ed;
    logic [31:0] mask;
    int n;
    n = q.size();
    chk("in_ready", 32'(wb.in_ready), 32'((n < DEPTH) || (find_merge(wb.in_addr[31:2]) >= 0)));
    chk("avm_write", 32'(wb.avm_write), 32'(n > 0));
    chk("avm_address", wb.avm_address, (n > 0) ? {q[0].a, 2'b00} : 32'h0);
    chk("avm_writedata", wb.avm_writedata, (n > 0) ? q[0].d : 32'h0);
    chk("avm_byteenable", 32'(wb.avm_byteenable), (n > 0) ? 32'(q[0].be) : 32'h0);
    chk("count", 32'(wb.count), 32'(n));
    chk("full", 32'(wb.full), 32'(n == DEPTH));
    chk("empty", 32'(wb.empty), 32'(n == 0));
    // per lane: the youngest pending write to the word that covers the lane
    eb = 4'h0;
    ed = 32'h0;
    for (int l = 0; l < 4; l++) begin
      for (int j = n - 1; j >= 0; j--) begin
        if (q[j].a == wb.lookup_addr[31:2] && q[j].be[l]) begin
          eb[l] = 1'b1;
          ed[8*l +: 8] = q[j].d[8*l +: 8];
          break;
        end
      end
    end
    mask = {{8{eb[3]}}, {8{eb[2]}}, {8{eb[1]}}, {8{eb[0]}}};
    chk("lookup_byteenable", 32'(wb.lookup_byteenable), 32'(eb));
    chk("lookup_hit", 32'(wb.lookup_hit), 32'(eb != 4'h0));
    chk("lookup_data", wb.lookup_data & mask, ed);
  endtask

  // one clock: check just before the edge, update the model at the edge
  task automatic cycle();
    logic [29:0] w;
    logic [31:0] d;
    logic [3:0]  be;
    bit acc, popm, r;
    int mj;
    ent_t e;
    @(negedge clk);
    if (chk_en) model_check();
    w    = wb.in_addr[31:2];
    d    = wb.in_data;
    be   = wb.in_byteenable;
    r    = rst_n;
    mj   = find_merge(w);
    acc  = wb.in_valid && ((q.size() < DEPTH) || (mj >= 0));
    popm = (q.size() > 0) && !wb.avm_waitrequest;
    @(posedge clk);
    if (!r) begin
      q.delete();
    end else begin
      if (acc && be != 4'h0) begin
        if (mj >= 0) begin
          e = q[mj];
          for (int l = 0; l < 4; l++) if (be[l]) e.d[8*l +: 8] = d[8*l +: 8];
          e.be = e.be | be;
          q[mj] = e;
        end else begin
          e.a = w; e.d = d; e.be = be;
          q.push_back(e);
        end
      end
      if (popm) void'(q.pop_front());
    end
    #1;
  endtask

  task automatic set_wr(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wb.in_valid = v; wb.in_addr = a; wb.in_data = d; wb.in_byteenable = be;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    cycle();
    cycle();
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] d;
    bit          wr;
    int          cnt;
    bit          rdy;
    bit          aw;
    logic [31:0] aaddr;
  } vec_t;
  vec_t tbl[19];

  initial begin
    // fill/full/drain table: expectations are the outputs seen before each row's edge
    for (int r = 0; r < 19; r++) begin
      tbl[r].a = (r < 9) ? 32'(4 * r) : 32'h20;
      tbl[r].d = 32'hA000_0000 + 32'(r);
      if (r < 9) begin
        tbl[r].v = 1'b1; tbl[r].wr = 1'b1; tbl[r].cnt = r;
        tbl[r].rdy = (r < 8); tbl[r].aw = (r > 0); tbl[r].aaddr = 32'h0;
      end else begin
        tbl[r].v = (r == 10); tbl[r].wr = 1'b0;
        tbl[r].cnt = (r == 9) ? 8 : (r == 10) ? 7 : 18 - r;
        tbl[r].rdy = (r != 9); tbl[r].aw = (r != 18);
        tbl[r].aaddr = (r == 18) ? 32'h0 : 32'(4 * (r - 9));
      end
    end

    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    wb.avm_waitrequest = 1'b0;
    wb.lookup_addr = 32'h0;

    // reset and single write
    do_reset();
    chk("rst_count", 32'(wb.count), 32'h0);
    chk("rst_empty", 32'(wb.empty), 32'h1);
    chk("rst_full", 32'(wb.full), 32'h0);
    chk("rst_avm_write", 32'(wb.avm_write), 32'h0);
    set_wr(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    cycle();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    chk("t1_avm_write", 32'(wb.avm_write), 32'h1);
    chk("t1_avm_address", wb.avm_address, 32'h100);
    chk("t1_avm_writedata", wb.avm_writedata, 32'hDEADBEEF);
    cycle();
    chk("t1_empty_after_pop", 32'(wb.empty), 32'h1);

    // fill to full, then drain in order with a 9th write accepted at count 7
    do_reset();
    for (int r = 0; r < 19; r++) begin
      set_wr(tbl[r].v, tbl[r].a, tbl[r].d, 4'hF);
      wb.avm_waitrequest = tbl[r].wr;
      #1;
      chk($sformatf("tbl%0d_count", r), 32'(wb.count), 32'(tbl[r].cnt));
      chk($sformatf("tbl%0d_in_ready", r), 32'(wb.in_ready), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d_avm_write", r), 32'(wb.avm_write), 32'(tbl[r].aw));
      chk($sformatf("tbl%0d_avm_address", r), wb.avm_address, tbl[r].aaddr);
      cycle();
    end
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);

    // waitrequest hold
    do_reset();
    wb.avm_waitrequest = 1'b1;
    set_wr(1'b1, 32'h40, 32'h4040_1234, 4'hF);
    cycle();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_write", 32'(wb.avm_write), 32'h1);
      chk("t3_hold_address", wb.avm_address, 32'h40);
      chk("t3_hold_data", wb.avm_writedata, 32'h4040_1234);
      chk("t3_hold_be", 32'(wb.avm_byteenable), 32'hF);
      cycle();
    end
    wb.avm_waitrequest = 1'b0;
    cycle();
    chk("t3_popped", 32'(wb.empty), 32'h1);

    // forwarding across two entries for one word
    do_reset();
    wb.avm_waitrequest = 1'b1;
    wb.lookup_addr = 32'h202;
    set_wr(1'b1, 32'h200, 32'h11223344, 4'b0011);
    cycle();
    set_wr(1'b1, 32'h200, 32'hAABBCCDD, 4'b0110);
    cycle();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    chk("t4_hit", 32'(wb.lookup_hit), 32'h1);
    chk("t4_be", 32'(wb.lookup_byteenable), 32'h7);
    chk("t4_data", wb.lookup_data & 32'h00FF_FFFF, 32'h00BB_CC44);
    cycle();

    // same-word writes behind the head
    do_reset();
    wb.avm_waitrequest = 1'b1;
    set_wr(1'b1, 32'h0, 32'h0101_0101, 4'hF);
    cycle();
    set_wr(1'b1, 32'h10, 32'h0000_00AA, 4'b0001);
    cycle();
    set_wr(1'b1, 32'h10, 32'hBB00_0000, 4'b1000);
    cycle();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
`ifdef WB_COALESCE_EN
    chk("t5_count", 32'(wb.count), 32'h2);
`else
    chk("t5_count", 32'(wb.count), 32'h3);
`endif
    wb.avm_waitrequest = 1'b0;
    cycle();
    chk("t5_addr", wb.avm_address, 32'h10);
`ifdef WB_COALESCE_EN
    chk("t5_data", wb.avm_writedata, 32'hBB00_00AA);
    chk("t5_be", 32'(wb.avm_byteenable), 32'h9);
`else
    chk("t5_data", wb.avm_writedata, 32'h0000_00AA);
    chk("t5_be", 32'(wb.avm_byteenable), 32'h1);
`endif
    cycle(); cycle(); cycle();

    // zero byte-enable write, then reset with entries pending on a stalled bus
    do_reset();
    wb.avm_waitrequest = 1'b1;
    set_wr(1'b1, 32'h500, 32'h1234_5678, 4'h0);
    #1;
    chk("t6_be0_ready", 32'(wb.in_ready), 32'h1);
    cycle();
    chk("t6_be0_count", 32'(wb.count), 32'h0);
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, 32'h600 + 32'(4 * i), 32'h6000 + 32'(i), 4'hF);
      cycle();
    end
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    chk("t6_pending", 32'(wb.count), 32'h3);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("t6_rst_avm_write", 32'(wb.avm_write), 32'h0);
    chk("t6_rst_count", 32'(wb.count), 32'h0);
    chk("t6_rst_empty", 32'(wb.empty), 32'h1);

    // randomized traffic against the queue model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int wrp;
      wrp = ((i / 500) % 2 == 0) ? 75 : 25;
      set_wr(1'($urandom_range(0, 1)),
             32'h300 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
             $urandom, 4'($urandom_range(0, 15)));
      wb.avm_waitrequest = ($urandom_range(0, 99) < wrp);
      wb.lookup_addr = 32'h300 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_n = 1'b1;
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cache_writebuffer_coalesce.md
Name: mips_cache_writebuffer_coalesce

Overview:
Parametrised-depth posted-write FIFO between the data cache and the Avalon-MM master port. Replaces the fixed 8-entry write buffer.
- Proper FIFO-ordered drain with waitrequest hold.
- Optional same-word write coalescing.
- Combinational read-forwarding lookup, so cache read misses observe buffered stores.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous reset, active low
in_valid  in  1  cache presents a write this cycle
in_addr  in  32  byte address; bits [1:0] ignored (word-aligned)
in_data  in  32  write data
in_byteenable  in  4  byte lanes to write
in_ready  out  1  buffer accepts the write this cycle
avm_address  out  32  Avalon address of head entry; bits [1:0] = 0
avm_write  out  1  Avalon write request
avm_writedata  out  32  head entry data
avm_byteenable  out  4  head entry byte enables
avm_waitrequest  in  1  slave stall
lookup_addr  in  32  word address probed by the cache read path
lookup_hit  out  1  any buffered byte of that word is pending
lookup_data  out  32  forwarded data (valid only in lanes flagged by lookup_byteenable)
lookup_byteenable  out  4  lanes supplied by the buffer
count  out  PTR_W+1  number of occupied entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
Reset
- Sampling rst_n=0 at a rising edge invalidates all entries and zeroes read/write pointers.
- Values after reset: count=0, empty=1, full=0, avm_write=0.
- Reset mid-transfer drops all pending writes, including the one on the bus.

Accept
- A write is accepted when in_valid && in_ready at the rising edge.
- in_ready = !full, or a coalesce match exists (see Optional Feature).
- Full blocks acceptance even if a pop occurs in the same cycle; there is no full-bypass.
- A write with in_byteenable==4'b0000 is accepted and discarded: no entry, count unchanged.

Entry and drain
- Each entry holds {valid, addr[31:2], data, be}. A new entry is written at the tail; the tail pointer wraps modulo DEPTH.
- Head drives avm_* combinationally from registers.
- avm_write = !empty. When empty, avm_address/avm_writedata/avm_byteenable = 0.
- Pop on avm_write && !avm_waitrequest: head is invalidated, the head pointer increments (wraps), count decrements.
- While avm_waitrequest=1, avm_* stay stable.

Latency
- A write accepted at edge N into an empty buffer asserts avm_write in cycle N+1.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.

Ordering
- Entries drain in acceptance order; merging (Optional Feature) is the only exception.

Lookup (purely combinational)
- Compares lookup_addr[31:2] against all valid entries.
- Per byte lane, the youngest matching entry with that lane enabled supplies the data.
- lookup_byteenable = OR of matching entries' be.
- lookup_hit = |lookup_byteenable.
- A write accepted at edge N is visible to lookup from cycle N+1.

Status
- count/full/empty are registered and consistent with entry valid bits every cycle.

Optional Feature:
Macro: WB_COALESCE_EN

Defined:
- An incoming write whose addr[31:2] matches a valid non-head entry merges into it instead of allocating.
- Merge rule: per lane with in_byteenable set, data replaced; be |= in_byteenable. Count unchanged.
- The head entry is never modified, since it may be on the bus; a match only on the head allocates a new entry.
- Merging is allowed when full, so in_ready=1 if a non-head match exists.
- At most one non-head entry per word address exists.

Undefined:
- Every non-discarded accepted write allocates an entry.
- in_ready = !full.
- Strict FIFO order.

Test Plan:
1. Reset/basic: rst_n=0 for 2 cycles, then write addr 0x100, data 0xDEADBEEF, be 4'hF with avm_waitrequest=0 -> avm_write=1 next cycle with avm_address=0x100, avm_writedata=0xDEADBEEF; empty=1 after pop.
2. Fill/full (DEPTH=8, waitrequest held 1): 8 writes to distinct words 0x0..0x1C -> count=8, full=1, in_ready=0. Release waitrequest -> bus sees 0x0,0x4,...,0x1C in order; a 9th write accepted once count=7.
3. Waitrequest hold: waitrequest=1 for 5 cycles with head 0x40 -> avm_* unchanged for all 5; pop on first cycle with waitrequest=0.
4. Forwarding: buffer holds 0x200/0x11223344/be 4'b0011 (older) and 0x200/0xAABBCCDD/be 4'b0110 (younger, coalescing off) -> lookup 0x202: hit=1, be=4'b0111, data lanes [2:0]=0xBBCC44.
5. Coalescing (WB_COALESCE_EN, waitrequest=1): writes 0x0 (head), 0x10 be 4'b0001 data 0x000000AA, 0x10 be 4'b1000 data 0xBB000000 -> count=2; entry 0x10 drains as 0xBB0000AA, be 4'b1001.
6. Edge cases: be=0 write -> count unchanged; reset asserted with 3 pending entries and waitrequest=1 -> next cycle avm_write=0, count=0, empty=1.
